// File: rtl/ddr3_line_reader_if.sv
`default_nettype none
// ============================================================================
// Module : ddr3_line_reader_if
// Brief  : Command, wrapper read request/return and pixel stream bundle.
// Rev    : 1.0
// ============================================================================
interface ddr3_line_reader_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0]       length;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              app_rd_data_valid;
  logic [63:0]       app_rd_data;
  logic              px_valid;
  logic [47:0]       px_data;
  logic              px_ready;
  logic              overflow;

  modport master (
    input  start, base_addr, length, app_rd_data_valid, app_rd_data, px_ready,
    output busy, done, rd_en, rd_addr, px_valid, px_data, overflow
  );

  modport slave (
    output start, base_addr, length, app_rd_data_valid, app_rd_data, px_ready,
    input  busy, done, rd_en, rd_addr, px_valid, px_data, overflow
  );
endinterface
`default_nettype wire

// File: rtl/ddr3_line_reader.sv
`default_nettype none
// ============================================================================
// Module : ddr3_line_reader
// Brief  : Credit-limited DDR3 word reader feeding a 48-bit pixel FIFO/stream.
// Rev    : 1.0
// ============================================================================
module ddr3_line_reader #(
  parameter int FIFO_DEPTH = 16,
  parameter int ISSUE_GAP  = 4,
  parameter int ADDR_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  ddr3_line_reader_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = $clog2(ISSUE_GAP) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(ISSUE_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       iss_left_q, iss_left_d;
  logic [15:0]       rx_left_q, rx_left_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [47:0]       mem_q [FIFO_DEPTH];

  logic active, pop, push_req, push, drop, issue;
  logic unused_hi_bits;

  assign unused_hi_bits = ^bus.app_rd_data[63:48];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    iss_left_d = iss_left_q;
    rx_left_d  = rx_left_q;
    out_d      = out_q;
    gap_d      = gap_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    active   = (state_q != S_IDLE);
    pop      = (count_q != '0) && bus.px_ready;
    push_req = active && bus.app_rd_data_valid;
    push     = push_req && ((count_q != DEPTH_C) || pop);
    drop     = push_req && !push;
    // Credits include in-flight requests so every return has a free slot.
    issue    = (state_q == S_ISSUE) && (gap_q == '0) && (iss_left_q != '0) &&
               (({1'b0, count_q} + {1'b0, out_q}) < {1'b0, DEPTH_C});

    if (gap_q != '0) gap_d = gap_q - 1'b1;
    if (issue) begin
      addr_d     = addr_q + 1'b1;
      iss_left_d = iss_left_q - 1'b1;
      gap_d      = GAP_RELOAD;
    end

    if (issue && !push_req)                      out_d = out_q + 1'b1;
    else if (!issue && push_req && out_q != '0)  out_d = out_q - 1'b1;

    if (push_req && rx_left_q != '0) rx_left_d = rx_left_q - 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop) overflow_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d     = bus.base_addr;
          iss_left_d = bus.length;
          rx_left_d  = bus.length;
          out_d      = '0;
          gap_d      = '0;
          // Zero length passes through DRAIN, so done lands two cycles after start.
          state_d    = (bus.length == 16'd0) ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: if (issue && iss_left_q == 16'd1) state_d = S_DRAIN;
      S_DRAIN: if (rx_left_d == 16'd0 && count_d == '0) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      iss_left_q <= '0;
      rx_left_q  <= '0;
      out_q      <= '0;
      gap_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      iss_left_q <= iss_left_d;
      rx_left_q  <= rx_left_d;
      out_q      <= out_d;
      gap_q      <= gap_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= bus.app_rd_data[47:0];
  end

  assign bus.rd_en    = issue;
  assign bus.rd_addr  = addr_q;
  assign bus.busy     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign bus.done     = (state_q == S_FIN);
  assign bus.px_valid = (count_q != '0);
  assign bus.px_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_line_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_ddr3_line_reader
// Brief  : Directed scoreboard bench with a read-return wrapper model.
// Rev    : 1.0
// ============================================================================
module tb_ddr3_line_reader;

  localparam int GAP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ddr3_line_reader_if #(.ADDR_W(16)) bus ();

  ddr3_line_reader #(.FIFO_DEPTH(16), .ISSUE_GAP(GAP), .ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wrapper model: answers each rd_en six cycles later; can also inject unsolicited words.
  typedef struct { int due; logic [63:0] data; } ret_t;
  ret_t pend[$];
  bit   model_en = 1'b1;
  int   inj_req  = 0;
  int   inj_done = 0;

  initial begin
    bus.app_rd_data_valid = 1'b0;
    bus.app_rd_data       = '0;
    forever begin
      @(posedge clk);
      #1;
      if (model_en && bus.rd_en)
        pend.push_back('{due: cyc + 6, data: {16'hAAAA, 16'hC0DE, 16'h0000, bus.rd_addr}});
      bus.app_rd_data_valid = 1'b0;
      bus.app_rd_data       = '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        bus.app_rd_data_valid = 1'b1;
        bus.app_rd_data       = pend[0].data;
        void'(pend.pop_front());
      end else if (inj_done < inj_req) begin
        bus.app_rd_data_valid = 1'b1;
        bus.app_rd_data       = {16'hAAAA, 16'hC0DE, 16'h0000, 16'hE000 + 16'(inj_done)};
        inj_done++;
      end
    end
  end

  // Monitor: checks request addresses/spacing and popped pixels against the queues.
  logic [15:0] exp_addr[$];
  logic [47:0] exp_px[$];
  bit chk_addr = 1'b1;
  int rd_cnt   = 0;
  int last_rd  = -100;
  int last_pop = -100;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.rd_en) begin
        rd_cnt++;
        check("rd_spacing_ok", 64'(cyc - last_rd >= GAP), 64'd1);
        last_rd = cyc;
        if (chk_addr) begin
          if (exp_addr.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_unexpected: got addr 0x%0h with nothing expected", bus.rd_addr);
          end else begin
            check("rd_addr", 64'(bus.rd_addr), 64'(exp_addr.pop_front()));
          end
        end
      end
      if (!rst && bus.px_valid && bus.px_ready) begin
        last_pop = cyc;
        if (exp_px.size() == 0) begin
          total++; bad++;
          $display("FAIL px_unexpected: got 0x%0h with nothing expected", bus.px_data);
        end else begin
          check("px_data", 64'(bus.px_data), 64'(exp_px.pop_front()));
        end
      end
    end
  end

  task automatic pulse_start(input logic [15:0] base, input logic [15:0] len);
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.length    = len;
    tick(1);
    bus.start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dcyc = cyc;
        break;
      end
    end
    total++;
    if (dcyc < 0) begin
      bad++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end else begin
      check("busy_low_at_done", 64'(bus.busy), 64'd0);
    end
    tick(1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, 64'({bus.busy, bus.done, bus.rd_en, bus.px_valid, bus.overflow}), 64'd0);
    check({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
    check({tag, "_px_data"}, 64'(bus.px_data), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, s, r0, n;
    logic [15:0] wrap_a [4];
    wrap_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.px_ready = 1'b0;
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    check_idle_outputs("reset");
    tick(1);
    rst = 1'b0;
    tick(2);

    // Basic run
    bus.px_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(16'h0010 + 16'(i));
      exp_px.push_back({16'hC0DE, 16'h0000, 16'h0010 + 16'(i)});
    end
    r0 = rd_cnt;
    pulse_start(16'h0010, 16'd4);
    @(negedge clk);
    check("basic_busy", 64'(bus.busy), 64'd1);
    wait_done(200, d);
    check("basic_done_after_last_pop", 64'(d - last_pop), 64'd1);
    check("basic_rd_count", 64'(rd_cnt - r0), 64'd4);
    check("basic_overflow", 64'(bus.overflow), 64'd0);
    check("basic_px_left", 64'(exp_px.size()), 64'd0);

    // Backpressure
    bus.px_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      exp_addr.push_back(16'h0100 + 16'(i));
      exp_px.push_back({16'hC0DE, 16'h0000, 16'h0100 + 16'(i)});
    end
    r0 = rd_cnt;
    pulse_start(16'h0100, 16'd40);
    tick(200);
    check("bp_rd_stall_count", 64'(rd_cnt - r0), 64'd16);
    @(negedge clk);
    check("bp_px_valid", 64'(bus.px_valid), 64'd1);
    check("bp_px_head", 64'(bus.px_data), 64'h0000_C0DE_0000_0100);
    tick(1);
    @(negedge clk);
    check("bp_px_hold", 64'(bus.px_data), 64'h0000_C0DE_0000_0100);
    check("bp_overflow", 64'(bus.overflow), 64'd0);
    tick(1);
    bus.px_ready = 1'b1;
    wait_done(800, d);
    check("bp_rd_total", 64'(rd_cnt - r0), 64'd40);
    check("bp_px_left", 64'(exp_px.size()), 64'd0);
    check("bp_overflow_end", 64'(bus.overflow), 64'd0);

    // Address wrap
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(wrap_a[i]);
      exp_px.push_back({16'hC0DE, 16'h0000, wrap_a[i]});
    end
    r0 = rd_cnt;
    pulse_start(16'hFFFE, 16'd4);
    wait_done(200, d);
    check("wrap_rd_count", 64'(rd_cnt - r0), 64'd4);
    check("wrap_px_left", 64'(exp_px.size()), 64'd0);

    // Zero length
    r0 = rd_cnt;
    s  = cyc;
    pulse_start(16'h0040, 16'd0);
    wait_done(20, d);
    check("zero_done_latency", 64'(d - s), 64'd2);
    check("zero_rd_count", 64'(rd_cnt - r0), 64'd0);

    // Start while busy is ignored
    for (int i = 0; i < 8; i++) begin
      exp_addr.push_back(16'h0200 + 16'(i));
      exp_px.push_back({16'hC0DE, 16'h0000, 16'h0200 + 16'(i)});
    end
    r0 = rd_cnt;
    pulse_start(16'h0200, 16'd8);
    tick(10);
    pulse_start(16'h0900, 16'd3);
    wait_done(300, d);
    check("busy_start_rd_count", 64'(rd_cnt - r0), 64'd8);
    check("busy_start_px_left", 64'(exp_px.size()), 64'd0);
    check("busy_start_addr_left", 64'(exp_addr.size()), 64'd0);

    // Overflow injection
    model_en     = 1'b0;
    chk_addr     = 1'b0;
    bus.px_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      exp_px.push_back({16'hC0DE, 16'h0000, 16'hE000 + 16'(i)});
    pulse_start(16'h0300, 16'd20);
    inj_req = inj_req + 17;
    tick(40);
    @(negedge clk);
    check("ovf_set", 64'(bus.overflow), 64'd1);
    check("ovf_px_head", 64'(bus.px_data), 64'h0000_C0DE_0000_E000);
    tick(1);
    bus.px_ready = 1'b1;
    tick(30);
    @(negedge clk);
    check("ovf_px_left", 64'(exp_px.size()), 64'd0);
    check("ovf_sticky", 64'(bus.overflow), 64'd1);
    check("ovf_fifo_empty", 64'(bus.px_valid), 64'd0);
    tick(1);
    rst = 1'b1;
    bus.px_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    @(negedge clk);
    check_idle_outputs("ovf_reset");
    tick(1);
    model_en = 1'b1;
    chk_addr = 1'b1;

    // Reset mid-run, late returns dropped
    bus.px_ready = 1'b1;
    for (int i = 0; i < 3; i++) exp_addr.push_back(16'h0400 + 16'(i));
    exp_px.push_back({16'hC0DE, 16'h0000, 16'h0400});
    pulse_start(16'h0400, 16'd10);
    n = 0;
    for (int i = 0; i < 100 && n < 3; i++) begin
      @(negedge clk);
      if (bus.rd_en) n++;
    end
    check("rm_three_issued", 64'(n), 64'd3);
    tick(1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(10);
    @(negedge clk);
    check_idle_outputs("rm_after_reset");
    check("rm_px_left", 64'(exp_px.size()), 64'd0);
    check("rm_addr_left", 64'(exp_addr.size()), 64'd0);
    tick(1);

    for (int i = 0; i < 2; i++) begin
      exp_addr.push_back(16'h0500 + 16'(i));
      exp_px.push_back({16'hC0DE, 16'h0000, 16'h0500 + 16'(i)});
    end
    r0 = rd_cnt;
    pulse_start(16'h0500, 16'd2);
    wait_done(200, d);
    check("rm_rerun_rd_count", 64'(rd_cnt - r0), 64'd2);
    check("rm_rerun_px_left", 64'(exp_px.size()), 64'd0);
    check("rm_rerun_overflow", 64'(bus.overflow), 64'd0);

    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
